// File: rtl/bus_mux_reg.sv
// Registered, fixed-priority CPU bus multiplexer: din > ALU > register file.
// Tracks bus ownership, sticky drive contention / illegal select, and transfer count.
module bus_mux_reg #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned SRC_W     = 4,
    parameter int unsigned CNT_W     = 8,
    parameter bit          HOLD_LAST = 1'b1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [DATA_W-1:0]            din,
    input  logic                         din_en,
    input  logic [DATA_W-1:0]            alu_out,
    input  logic                         gout,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_bus,
    input  logic [SEL_W-1:0]             r_out,
    input  logic                         reg_oe,
    input  logic                         stall,
    input  logic                         clr_err,
    output logic [DATA_W-1:0]            bus_out,
    output logic                         bus_valid,
    output logic [SRC_W-1:0]             bus_src,
    output logic                         conflict_err,
    output logic [CNT_W-1:0]             xfer_cnt
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [DATA_W-1:0]  r_bus,   w_bus_nxt;
    logic [SRC_W-1:0]   r_src,   w_src_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic               r_err,   w_err_nxt;

    logic [DATA_W-1:0]  w_sel_data;
    logic               w_sel_found;
    logic               w_multi;
    logic               w_illegal;
    logic               w_err_set;
    logic               w_win;
    logic [DATA_W-1:0]  w_win_data;
    logic [SRC_W-1:0]   w_win_tag;

    // A select that matches no implemented register leaves w_sel_found low.
    always_comb begin
        w_sel_data  = '0;
        w_sel_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_out == SEL_W'(i)) begin
                w_sel_data  = reg_bus[i*DATA_W +: DATA_W];
                w_sel_found = 1'b1;
            end
        end
    end

    assign w_multi   = (din_en & gout) | (din_en & reg_oe) | (gout & reg_oe);
    assign w_illegal = reg_oe & ~din_en & ~gout & ~w_sel_found;
    assign w_err_set = ~stall & (w_multi | w_illegal);

    always_comb begin
        w_win      = 1'b1;
        w_win_data = w_sel_data;
        w_win_tag  = '0;
        if (din_en) begin
            w_win_data = din;
            w_win_tag  = SRC_W'(NUM_REGS + 1);
        end else if (gout) begin
            w_win_data = alu_out;
            w_win_tag  = SRC_W'(NUM_REGS);
        end else if (reg_oe && w_sel_found) begin
            w_win_tag  = SRC_W'(r_out);
        end else begin
            w_win      = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bus_nxt   = r_bus;
        w_src_nxt   = r_src;
        w_cnt_nxt   = r_cnt;
        if (!stall) begin
            if (w_win) begin
                w_state_nxt = S_DRIVE;
                w_bus_nxt   = w_win_data;
                w_src_nxt   = w_win_tag;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
            end else begin
                w_state_nxt = S_IDLE;
                if (!HOLD_LAST) w_bus_nxt = '0;
            end
        end
        // A new error outranks a simultaneous clear; clear works during stall.
        if (w_err_set)    w_err_nxt = 1'b1;
        else if (clr_err) w_err_nxt = 1'b0;
        else              w_err_nxt = r_err;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_bus   <= '0;
            r_src   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bus   <= w_bus_nxt;
            r_src   <= w_src_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus_out      = r_bus;
    assign bus_valid    = (r_state == S_DRIVE);
    assign bus_src      = r_src;
    assign conflict_err = r_err;
    assign xfer_cnt     = r_cnt;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Self-checking bench for bus_mux_reg: directed vector table, corner sequences,
// and randomized traffic against a behavioural model (HOLD_LAST 1 and 0).
module tb_bus_mux_reg;

    logic         clk;
    logic         resetn;
    logic [15:0]  din;
    logic         din_en;
    logic [15:0]  alu_out;
    logic         gout;
    logic [127:0] reg_bus;
    logic [2:0]   r_out;
    logic         reg_oe;
    logic         stall;
    logic         clr_err;

    logic [15:0] d_bus, h_bus, c_bus, n_bus;
    logic        d_v, h_v, c_v, n_v;
    logic [3:0]  d_src, h_src, c_src, n_src;
    logic        d_err, h_err, c_err, n_err;
    logic [7:0]  d_cnt, h_cnt, n_cnt;
    logic [1:0]  c_cnt;

    int checks   = 0;
    int failures = 0;

    bus_mux_reg u_dut (
        .clk(clk), .resetn(resetn), .din(din), .din_en(din_en), .alu_out(alu_out),
        .gout(gout), .reg_bus(reg_bus), .r_out(r_out), .reg_oe(reg_oe), .stall(stall),
        .clr_err(clr_err), .bus_out(d_bus), .bus_valid(d_v), .bus_src(d_src),
        .conflict_err(d_err), .xfer_cnt(d_cnt)
    );

    bus_mux_reg #(.HOLD_LAST(1'b0)) u_h0 (
        .clk(clk), .resetn(resetn), .din(din), .din_en(din_en), .alu_out(alu_out),
        .gout(gout), .reg_bus(reg_bus), .r_out(r_out), .reg_oe(reg_oe), .stall(stall),
        .clr_err(clr_err), .bus_out(h_bus), .bus_valid(h_v), .bus_src(h_src),
        .conflict_err(h_err), .xfer_cnt(h_cnt)
    );

    bus_mux_reg #(.CNT_W(2)) u_c2 (
        .clk(clk), .resetn(resetn), .din(din), .din_en(din_en), .alu_out(alu_out),
        .gout(gout), .reg_bus(reg_bus), .r_out(r_out), .reg_oe(reg_oe), .stall(stall),
        .clr_err(clr_err), .bus_out(c_bus), .bus_valid(c_v), .bus_src(c_src),
        .conflict_err(c_err), .xfer_cnt(c_cnt)
    );

    bus_mux_reg #(.NUM_REGS(6), .SEL_W(3)) u_n6 (
        .clk(clk), .resetn(resetn), .din(din), .din_en(din_en), .alu_out(alu_out),
        .gout(gout), .reg_bus(reg_bus[95:0]), .r_out(r_out), .reg_oe(reg_oe), .stall(stall),
        .clr_err(clr_err), .bus_out(n_bus), .bus_valid(n_v), .bus_src(n_src),
        .conflict_err(n_err), .xfer_cnt(n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        de, g, ro;
        logic [2:0]  sel;
        logic        st, clr;
        logic [15:0] bus;
        logic        v;
        logic [3:0]  src;
        logic        err;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [25];

    // Behavioural model state: index 0 = HOLD_LAST=1, index 1 = HOLD_LAST=0.
    int m_bus [2];
    int m_v   [2];
    int m_src [2];
    int m_err [2];
    int m_cnt [2];

    function automatic vec_t mk(input logic de, g, ro, input int sel, input logic st, clr,
                                input int bus, input logic v, input int src, input logic err,
                                input int cnt);
        vec_t r;
        r.de = de; r.g = g; r.ro = ro; r.sel = sel[2:0]; r.st = st; r.clr = clr;
        r.bus = bus[15:0]; r.v = v; r.src = src[3:0]; r.err = err; r.cnt = cnt[7:0];
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        din_en = 0; gout = 0; reg_oe = 0; r_out = 0; stall = 0; clr_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic model_step(input int k, input bit hold);
        int  nreq;
        int  win_tag;
        int  win_data;
        bit  legal;
        nreq  = int'(din_en) + int'(gout) + int'(reg_oe);
        legal = reg_oe && (int'(r_out) < 8);
        if (!stall) begin
            win_tag = -1;
            win_data = 0;
            if (din_en)     begin win_tag = 9; win_data = int'(din); end
            else if (gout)  begin win_tag = 8; win_data = int'(alu_out); end
            else if (legal) begin win_tag = int'(r_out); win_data = int'(reg_bus[r_out*16 +: 16]); end
            if (nreq > 1 || (reg_oe && !legal && nreq == 1)) m_err[k] = 1;
            else if (clr_err) m_err[k] = 0;
            if (win_tag >= 0) begin
                m_bus[k] = win_data;
                m_v[k]   = 1;
                m_src[k] = win_tag;
                m_cnt[k] = (m_cnt[k] + 1) % 256;
            end else begin
                m_v[k] = 0;
                if (!hold) m_bus[k] = 0;
            end
        end else if (clr_err) begin
            m_err[k] = 0;
        end
    endtask

    initial begin
        resetn = 1'b1;
        din = 16'hABCD;
        alu_out = 16'h0009;
        for (int i = 0; i < 8; i++) reg_bus[i*16 +: 16] = 16'(i + 1);
        idle_inputs();

        // Asynchronous reset with no clock edge yet.
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_bus", int'(d_bus), 0);
        chk("rst_async_valid", int'(d_v), 0);
        chk("rst_async_src", int'(d_src), 0);
        chk("rst_async_err", int'(d_err), 0);
        chk("rst_async_cnt", int'(d_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("post_rst_valid", int'(d_v), 0);

        tbl[0]  = mk(0,0,0,0,0,0, 16'h0000,0,0,0,0);
        for (int i = 0; i < 8; i++)
            tbl[1+i] = mk(0,0,1,i,0,0, i+1,1,i,0,i+1);
        tbl[9]  = mk(1,1,1,0,0,0, 16'hABCD,1,9,1,9);
        tbl[10] = mk(0,1,1,0,0,0, 16'h0009,1,8,1,10);
        tbl[11] = mk(0,0,0,0,0,1, 16'h0009,0,8,0,10);
        tbl[12] = mk(1,1,0,0,0,1, 16'hABCD,1,9,1,11);
        tbl[13] = mk(0,0,0,0,0,1, 16'hABCD,0,9,0,11);
        tbl[14] = mk(0,1,0,0,0,0, 16'h0009,1,8,0,12);
        tbl[15] = mk(1,0,0,0,1,0, 16'h0009,1,8,0,12);
        tbl[16] = mk(1,0,0,0,1,0, 16'h0009,1,8,0,12);
        tbl[17] = mk(1,0,0,0,1,0, 16'h0009,1,8,0,12);
        tbl[18] = mk(1,0,0,0,0,0, 16'hABCD,1,9,0,13);
        tbl[19] = mk(0,0,1,3,0,0, 16'h0004,1,3,0,14);
        tbl[20] = mk(0,0,0,0,0,0, 16'h0004,0,3,0,14);
        tbl[21] = mk(0,1,1,2,0,0, 16'h0009,1,8,1,15);
        tbl[22] = mk(1,0,0,0,1,1, 16'h0009,1,8,0,15);
        tbl[23] = mk(1,1,0,0,1,0, 16'h0009,1,8,0,15);
        tbl[24] = mk(0,0,1,7,0,0, 16'h0008,1,7,0,16);

        for (int i = 0; i < 25; i++) begin
            din_en = tbl[i].de; gout = tbl[i].g; reg_oe = tbl[i].ro; r_out = tbl[i].sel;
            stall = tbl[i].st; clr_err = tbl[i].clr;
            tick();
            chk($sformatf("vec%0d_bus", i),   int'(d_bus), int'(tbl[i].bus));
            chk($sformatf("vec%0d_valid", i), int'(d_v),   int'(tbl[i].v));
            chk($sformatf("vec%0d_src", i),   int'(d_src), int'(tbl[i].src));
            chk($sformatf("vec%0d_err", i),   int'(d_err), int'(tbl[i].err));
            chk($sformatf("vec%0d_cnt", i),   int'(d_cnt), int'(tbl[i].cnt));
        end
        idle_inputs();

        // Idle behaviour with HOLD_LAST=1 vs 0.
        reg_oe = 1; r_out = 3;
        tick();
        idle_inputs();
        tick();
        chk("hold1_bus", int'(d_bus), 16'h0004);
        chk("hold1_valid", int'(d_v), 0);
        chk("hold0_bus", int'(h_bus), 0);
        chk("hold0_valid", int'(h_v), 0);
        chk("hold0_src", int'(h_src), 3);

        // Mid-cycle asynchronous reset.
        gout = 1;
        tick();
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("midrst_bus", int'(d_bus), 0);
        chk("midrst_valid", int'(d_v), 0);
        chk("midrst_cnt", int'(d_cnt), 0);
        chk("midrst_src", int'(d_src), 0);
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("midrst_discard_valid", int'(d_v), 0);

        // Counter wrap on the 2-bit instance.
        gout = 1;
        for (int i = 0; i < 5; i++) tick();
        chk("wrap_c2_cnt", int'(c_cnt), 1);
        chk("wrap_dut_cnt", int'(d_cnt), 5);
        chk("wrap_c2_err", int'(c_err), 0);

        // Illegal select on the 6-register instance; legal on the 8-register one.
        gout = 0; reg_oe = 1; r_out = 7;
        tick();
        chk("illegal_n6_valid", int'(n_v), 0);
        chk("illegal_n6_err", int'(n_err), 1);
        chk("illegal_n6_cnt", int'(n_cnt), 5);
        chk("legal_dut_valid", int'(d_v), 1);
        chk("legal_dut_err", int'(d_err), 0);
        idle_inputs();

        // Randomized traffic against the behavioural model.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_bus[k] = 0; m_v[k] = 0; m_src[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            din     = 16'($urandom);
            alu_out = 16'($urandom);
            for (int i = 0; i < 8; i++) reg_bus[i*16 +: 16] = 16'($urandom);
            din_en  = ($urandom_range(0, 3) == 0);
            gout    = ($urandom_range(0, 3) == 0);
            reg_oe  = ($urandom_range(0, 1) == 0);
            r_out   = 3'($urandom_range(0, 7));
            stall   = ($urandom_range(0, 4) == 0);
            clr_err = ($urandom_range(0, 5) == 0);
            model_step(0, 1'b1);
            model_step(1, 1'b0);
            tick();
            chk($sformatf("rnd%0d_bus", n),    int'(d_bus), m_bus[0]);
            chk($sformatf("rnd%0d_valid", n),  int'(d_v),   m_v[0]);
            chk($sformatf("rnd%0d_src", n),    int'(d_src), m_src[0]);
            chk($sformatf("rnd%0d_err", n),    int'(d_err), m_err[0]);
            chk($sformatf("rnd%0d_cnt", n),    int'(d_cnt), m_cnt[0]);
            chk($sformatf("rnd%0d_h0bus", n),  int'(h_bus), m_bus[1]);
            chk($sformatf("rnd%0d_h0valid", n), int'(h_v),  m_v[1]);
            chk($sformatf("rnd%0d_h0src", n),  int'(h_src), m_src[1]);
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
Parametrised, registered successor to the CPU datapath bus multiplexer. It selects one of NUM_REGS register outputs, the ALU result or external data onto the shared bus. Selection is fixed-priority. The bus value is registered, with a valid flag and a source tag, and the block holds on stall. It also flags drive contention and counts completed transfers. It sits between the register file/ALU and every bus consumer (register load enables, ALU A/G latches).

Parameters:
DATA_W, 16, bus and operand width in bits
NUM_REGS, 8, number of general registers on the bus (2..16)
SEL_W, 3, register select width; must satisfy 2**SEL_W >= NUM_REGS
SRC_W, 4, source tag width; must satisfy 2**SRC_W >= NUM_REGS+2
CNT_W, 8, transfer counter width
HOLD_LAST, 1, 1 = bus keeps its last value when undriven; 0 = bus returns to zero

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  reset; asynchronous, active-low
din  in  DATA_W  external data input
din_en  in  1  request to drive din
alu_out  in  DATA_W  ALU result (G register)
gout  in  1  request to drive alu_out
reg_bus  in  NUM_REGS*DATA_W  flattened registers; r(i) = reg_bus[i*DATA_W +: DATA_W]
r_out  in  SEL_W  register select (binary)
reg_oe  in  1  request to drive register r_out
stall  in  1  freeze all state this cycle
clr_err  in  1  clear sticky conflict_err
bus_out  out  DATA_W  registered bus value
bus_valid  out  1  bus_out was driven by a source in the previous cycle
bus_src  out  SRC_W  tag of last winner: 0..NUM_REGS-1 = register index, NUM_REGS = ALU, NUM_REGS+1 = din
conflict_err  out  1  sticky: more than one request, or an illegal select, has occurred
xfer_cnt  out  CNT_W  count of valid transfers, wraps modulo 2**CNT_W

Behaviour:
- Reset is asynchronous, active-low. While resetn=0: bus_out=0, bus_valid=0, bus_src=0, conflict_err=0, xfer_cnt=0. Deassertion takes effect at the next rising edge. Reset mid-transfer discards the pending request.
- All outputs are registered. Latency is one cycle from request to bus_out/bus_valid.
- Priority when stall=0: din_en > gout > reg_oe. The winner's data is loaded into bus_out, bus_valid<=1, bus_src<=winner tag, and xfer_cnt increments.
- Illegal select: reg_oe=1 as the sole request with r_out >= NUM_REGS. No drive occurs and conflict_err<=1. The rest is handled as the no-request case.
- No request (or illegal select only):
  - bus_valid<=0; bus_src holds; xfer_cnt holds.
  - bus_out holds if HOLD_LAST=1, else bus_out<=0.
- Contention: two or three requests asserted in the same unstalled cycle. The priority winner still drives, and conflict_err<=1 at the same edge.
- conflict_err stays set until clr_err=1 is sampled, then returns to 0 at that edge. If a new error and clr_err occur in the same cycle, set wins and conflict_err stays 1. clr_err is honoured even while stall=1.
- stall=1: bus_out, bus_valid, bus_src and xfer_cnt hold. Requests are ignored and not queued, and contention is not evaluated.
- xfer_cnt wraps from 2**CNT_W-1 to 0 without any flag.
- Inputs are sampled only at the clock edge. There is no combinational path from any input to any output.
- Two-state control, derivable from bus_valid: IDLE (bus_valid=0) and DRIVE (bus_valid=1).
  - IDLE->DRIVE on a legal request with stall=0.
  - DRIVE->IDLE on no legal request with stall=0.
  - Any state holds on stall=1.

Test Plan:
(Defaults throughout; registers r0..r7 = 0x0001..0x0008, alu_out=0x0009, din=0xABCD.)
- Reset check: resetn=0 mid-cycle -> all outputs 0 immediately without a clock edge; after release with no requests -> bus_valid stays 0.
- Register sweep: reg_oe=1, r_out stepping 0..7, one per cycle -> one cycle later bus_out=0x0001..0x0008, bus_src=0..7, bus_valid=1; xfer_cnt=8 at the end.
- Priority and contention:
  - din_en=gout=reg_oe=1 -> bus_out=0xABCD, bus_src=9, conflict_err=1.
  - Next cycle gout+reg_oe -> bus_out=0x0009, bus_src=8.
  - clr_err pulse -> conflict_err=0.
  - clr_err together with a new gout+din_en -> conflict_err remains 1.
- Stall: drive alu (bus_out=0x0009), then stall=1 with din_en=1 for 3 cycles -> bus_out=0x0009 and xfer_cnt unchanged; stall=0 with din_en=1 -> bus_out=0xABCD on the next edge.
- Idle/HOLD_LAST: after bus_out=0x0004, drop all requests. With HOLD_LAST=1 -> bus_out=0x0004, bus_valid=0. With HOLD_LAST=0 -> bus_out=0x0000, bus_valid=0, bus_src=3.
- Wrap and illegal select:
  - CNT_W=2, 5 transfers -> xfer_cnt=1.
  - NUM_REGS=6, SEL_W=3, reg_oe=1, r_out=7 -> bus_valid=0, conflict_err=1.
